// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller and its storage array.
package dmem_pkg;

  localparam int unsigned DMEM_DW         = 32;
  localparam int unsigned DMEM_AW         = 5;
  localparam int unsigned DMEM_STARVE_MAX = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  localparam logic REQ_C = 1'b0;
  localparam logic REQ_L = 1'b1;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 2^AW x DW, registered read data, contents not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DW = DMEM_DW,
  parameter int unsigned AW = DMEM_AW
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Read register only updates on reads, so it holds the last read word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Arbiter and zero-fill sequencer sharing one data-memory port between the core (C)
// and the loader (L), with anti-starvation for L.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DW         = DMEM_DW,
  parameter int unsigned AW         = DMEM_AW,
  parameter int unsigned STARVE_MAX = DMEM_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          busy,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [31:0]   c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata
);

  localparam int unsigned    SW         = $clog2(STARVE_MAX + 1);
  localparam logic [AW-1:0]  PTR_LAST   = AW'(2 ** AW - 1);
  localparam logic [SW-1:0]  STARVE_SAT = SW'(STARVE_MAX);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          c_rvalid_q, c_rvalid_d;
  logic          l_rvalid_q, l_rvalid_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] l_rdata_q, l_rdata_d;

  logic          c_gnt_c, l_gnt_c;
  logic          gnt_id_c;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^{c_addr[31:AW], l_addr[31:AW]};

  // Arbitration: clear request blocks all grants; starved L beats C; else C before L.
  always_comb begin
    c_gnt_c = 1'b0;
    l_gnt_c = 1'b0;
    if (!rst && state_q == ST_SERVE && !clear_req) begin
      if (starve_q == STARVE_SAT && l_req) begin
        l_gnt_c = 1'b1;
      end else if (c_req) begin
        c_gnt_c = 1'b1;
      end else if (l_req) begin
        l_gnt_c = 1'b1;
      end
    end
  end

  assign gnt_id_c = l_gnt_c ? REQ_L : REQ_C;

  // Next state and RAM port steering.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = ptr_q;
    mem_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        ptr_d  = ptr_q + AW'(1);
        if (ptr_q == PTR_LAST) begin
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else if (c_gnt_c || l_gnt_c) begin
          mem_en    = 1'b1;
          mem_we    = (gnt_id_c == REQ_L) ? l_we : c_we;
          mem_addr  = (gnt_id_c == REQ_L) ? l_addr[AW-1:0] : c_addr[AW-1:0];
          mem_wdata = (gnt_id_c == REQ_L) ? l_wdata : c_wdata;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Starvation counter and per-requester read return.
  always_comb begin
    starve_d = starve_q;
    if (!l_req || l_gnt_c) begin
      starve_d = '0;
    end else if (starve_q != STARVE_SAT) begin
      starve_d = starve_q + SW'(1);
    end
    c_rvalid_d = c_gnt_c & ~c_we;
    l_rvalid_d = l_gnt_c & ~l_we;
    c_rdata_d  = c_rvalid_q ? mem_rdata : c_rdata_q;
    l_rdata_d  = l_rvalid_q ? mem_rdata : l_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      starve_q   <= '0;
      c_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      starve_q   <= starve_d;
      c_rvalid_q <= c_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      l_rdata_q  <= l_rdata_d;
    end
  end

  dmem_array #(
    .DW (DW),
    .AW (AW)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Fresh RAM data is forwarded in the rvalid cycle, then held in the rdata register.
  assign busy     = rst | (state_q == ST_CLEAR);
  assign c_gnt    = c_gnt_c;
  assign l_gnt    = l_gnt_c;
  assign c_rvalid = c_rvalid_q;
  assign l_rvalid = l_rvalid_q;
  assign c_rdata  = c_rvalid_q ? mem_rdata : c_rdata_q;
  assign l_rdata  = l_rvalid_q ? mem_rdata : l_rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: zero-fill, core/loader access, arbitration.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst, clear_req, busy;
  logic        c_req, c_we, c_gnt, c_rvalid;
  logic        l_req, l_we, l_gnt, l_rvalid;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [31:0] l_addr, l_wdata, l_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_gnt     (c_gnt),
    .c_rvalid  (c_rvalid),
    .c_rdata   (c_rdata),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_gnt     (l_gnt),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    int cnt, bad;
    rst = 1'b1; clear_req = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd7; c_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_cmp++; if (c_gnt !== 1'b0) begin n_err++; $display("FAIL reset_c_gnt: got %b want 0", c_gnt); end
    n_cmp++; if (c_rvalid !== 1'b0 || l_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b/%b want 0/0", c_rvalid, l_rvalid); end
    n_cmp++; if (c_rdata !== 32'h0 || l_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h/%h want 0/0", c_rdata, l_rdata); end
    rst = 1'b0;
    #1;
    cnt = 0; bad = 0;
    while (busy === 1'b1 && cnt < 40) begin
      if (c_gnt !== 1'b0 || l_gnt !== 1'b0) bad++;
      @(posedge clk); #1;
      cnt++;
    end
    n_cmp++; if (cnt != 32) begin n_err++; $display("FAIL reset_busy_len: got %0d want 32", cnt); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL reset_no_grant: got %0d grants want 0", bad); end
    n_cmp++; if (c_gnt !== 1'b1) begin n_err++; $display("FAIL reset_held_gnt: got %b want 1", c_gnt); end
    @(posedge clk); #1;
    c_addr = 32'd31;
    #1;
    n_cmp++; if (c_rvalid !== 1'b1 || c_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rd7: got %b/%h want 1/00000000", c_rvalid, c_rdata); end
    n_cmp++; if (c_gnt !== 1'b1) begin n_err++; $display("FAIL reset_rd31_gnt: got %b want 1", c_gnt); end
    @(posedge clk); #1;
    c_req = 1'b0;
    #1;
    n_cmp++; if (c_rvalid !== 1'b1 || c_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rd31: got %b/%h want 1/00000000", c_rvalid, c_rdata); end
  endtask

  task automatic test_c_write_read();
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h0000_0044; c_wdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (c_gnt !== 1'b1) begin n_err++; $display("FAIL cwr_wr_gnt: got %b want 1", c_gnt); end
    @(posedge clk); #1;
    c_we = 1'b0;
    #1;
    n_cmp++; if (c_rvalid !== 1'b0) begin n_err++; $display("FAIL cwr_wr_no_rvalid: got %b want 0", c_rvalid); end
    n_cmp++; if (c_gnt !== 1'b1) begin n_err++; $display("FAIL cwr_rd_gnt: got %b want 1", c_gnt); end
    @(posedge clk); #1;
    c_addr = 32'hFFFF_FFE4;
    #1;
    n_cmp++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL cwr_rd: got %b/%h want 1/deadbeef", c_rvalid, c_rdata); end
    n_cmp++; if (c_gnt !== 1'b1) begin n_err++; $display("FAIL cwr_wrap_gnt: got %b want 1", c_gnt); end
    @(posedge clk); #1;
    c_req = 1'b0;
    #1;
    n_cmp++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL cwr_wrap_rd: got %b/%h want 1/deadbeef", c_rvalid, c_rdata); end
    @(posedge clk); #1;
    n_cmp++; if (c_rvalid !== 1'b0 || c_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL cwr_hold: got %b/%h want 0/deadbeef", c_rvalid, c_rdata); end
  endtask

  task automatic test_starve();
    logic exp_l;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd0;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'd3; l_wdata = 32'h11;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_l = (i % 5 == 4);
      n_cmp++;
      if (l_gnt !== exp_l || c_gnt !== !exp_l) begin
        n_err++; $display("FAIL starve_cyc%0d: got c=%b l=%b want c=%b l=%b", i, c_gnt, l_gnt, !exp_l, exp_l);
      end
      @(posedge clk); #1;
    end
    c_req = 1'b0; l_req = 1'b0;
    #1;
    n_cmp++; if (l_rvalid !== 1'b0) begin n_err++; $display("FAIL starve_l_wr_no_rvalid: got %b want 0", l_rvalid); end
  endtask

  task automatic test_l_read();
    @(posedge clk); #1;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'd3;
    #1;
    n_cmp++; if (l_gnt !== 1'b1 || c_gnt !== 1'b0) begin n_err++; $display("FAIL lrd_gnt: got c=%b l=%b want c=0 l=1", c_gnt, l_gnt); end
    @(posedge clk); #1;
    l_req = 1'b0;
    #1;
    n_cmp++; if (l_rvalid !== 1'b1 || l_rdata !== 32'h11) begin n_err++; $display("FAIL lrd_data: got %b/%h want 1/00000011", l_rvalid, l_rdata); end
    n_cmp++; if (c_rvalid !== 1'b0 || c_rdata !== 32'h0) begin n_err++; $display("FAIL lrd_c_unchanged: got %b/%h want 0/00000000", c_rvalid, c_rdata); end
    @(posedge clk); #1;
    n_cmp++; if (l_rvalid !== 1'b0 || l_rdata !== 32'h11) begin n_err++; $display("FAIL lrd_hold: got %b/%h want 0/00000011", l_rvalid, l_rdata); end
  endtask

  task automatic test_back_to_back();
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h0000_0025; l_wdata = 32'h55;
    #1;
    n_cmp++; if (l_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_wr_gnt: got %b want 1", l_gnt); end
    @(posedge clk); #1;
    l_we = 1'b0; l_addr = 32'd5;
    #1;
    n_cmp++; if (l_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_rd_gnt: got %b want 1", l_gnt); end
    @(posedge clk); #1;
    l_req = 1'b0;
    #1;
    n_cmp++; if (l_rvalid !== 1'b1 || l_rdata !== 32'h55) begin n_err++; $display("FAIL b2b_rd: got %b/%h want 1/00000055", l_rvalid, l_rdata); end
  endtask

  task automatic test_clear_req();
    int cnt, bad;
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'd9; c_wdata = 32'hA5;
    #1;
    n_cmp++; if (c_gnt !== 1'b1) begin n_err++; $display("FAIL clr_wr_gnt: got %b want 1", c_gnt); end
    @(posedge clk); #1;
    c_we = 1'b0;
    #1;
    n_cmp++; if (c_gnt !== 1'b1) begin n_err++; $display("FAIL clr_rd_gnt: got %b want 1", c_gnt); end
    @(posedge clk); #1;
    clear_req = 1'b1;
    #1;
    n_cmp++; if (c_gnt !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL clr_req_cycle: got gnt=%b busy=%b want 0/0", c_gnt, busy); end
    n_cmp++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hA5) begin n_err++; $display("FAIL clr_inflight_rd: got %b/%h want 1/000000a5", c_rvalid, c_rdata); end
    @(posedge clk); #1;
    clear_req = 1'b0;
    #1;
    cnt = 0; bad = 0;
    while (busy === 1'b1 && cnt < 40) begin
      if (c_gnt !== 1'b0 || l_gnt !== 1'b0) bad++;
      @(posedge clk); #1;
      cnt++;
    end
    n_cmp++; if (cnt != 32) begin n_err++; $display("FAIL clr_busy_len: got %0d want 32", cnt); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL clr_no_grant: got %0d grants want 0", bad); end
    n_cmp++; if (c_gnt !== 1'b1) begin n_err++; $display("FAIL clr_held_gnt: got %b want 1", c_gnt); end
    @(posedge clk); #1;
    c_req = 1'b0;
    #1;
    n_cmp++; if (c_rvalid !== 1'b1 || c_rdata !== 32'h0) begin n_err++; $display("FAIL clr_rd9: got %b/%h want 1/00000000", c_rvalid, c_rdata); end
  endtask

  task automatic test_rst_mid_clear();
    int cnt, bad;
    @(posedge clk); #1;
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd20;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1 || c_gnt !== 1'b0) begin n_err++; $display("FAIL rst_mid_outs: got busy=%b gnt=%b want 1/0", busy, c_gnt); end
    n_cmp++; if (l_rdata !== 32'h0 || c_rdata !== 32'h0 || l_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid_rdata: got l=%h c=%h lv=%b want 0/0/0", l_rdata, c_rdata, l_rvalid); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    cnt = 0; bad = 0;
    while (busy === 1'b1 && cnt < 40) begin
      if (c_gnt !== 1'b0) bad++;
      @(posedge clk); #1;
      cnt++;
    end
    n_cmp++; if (cnt != 32) begin n_err++; $display("FAIL rst_mid_busy_len: got %0d want 32", cnt); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rst_mid_no_grant: got %0d grants want 0", bad); end
    n_cmp++; if (c_gnt !== 1'b1) begin n_err++; $display("FAIL rst_mid_gnt: got %b want 1", c_gnt); end
    @(posedge clk); #1;
    c_req = 1'b0;
    #1;
    n_cmp++; if (c_rvalid !== 1'b1 || c_rdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_rd20: got %b/%h want 1/00000000", c_rvalid, c_rdata); end
  endtask

  initial begin
    test_reset();
    test_c_write_read();
    test_starve();
    test_l_read();
    test_back_to_back();
    test_clear_req();
    test_rst_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
